sipo_word_deser: RTL
====================

Name: sipo_word_deser

Overview:
- Serial-in/parallel-out deserializer that assembles framed serial bits into BITWIDTH-bit words.
- Sits directly upstream of the team's N-bit enable register.
- `word` drives the register's data input; `word_valid` drives its load enable.
- Framing is marked by a start-of-word strobe; malformed frames are flagged and resynchronised.

Parameters:
- BITWIDTH, 16, word width in bits; must be >= 2.
- MSB_FIRST, 1:
  - 1 = first serial bit lands in word[BITWIDTH-1].
  - 0 = first serial bit lands in word[0].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_in  input  1  serial data bit.
- sof  input  1  start-of-word marker; meaningful only when bit_valid=1; tags the first bit of a word.
- word  output  BITWIDTH  last completed word; registered.
- word_valid  output  1  one-cycle pulse when word updates; registered.
- busy  output  1  a word is partially assembled (state SHIFT); registered.
- frame_err  output  1  one-cycle pulse when a word is aborted by an early sof; registered.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit counter=0, shift register=0, word=0, word_valid=0, busy=0, frame_err=0. Release is synchronous to the next rising edge.
- Internal state:
  - Bit counter is $clog2(BITWIDTH) bits wide and counts bits accepted in the current word.
  - Shift register is BITWIDTH bits.
- FSM states: IDLE, SHIFT.
- IDLE:
  - bit_valid=1 & sof=1: accept bit as first bit, counter=1, go to SHIFT.
  - bit_valid=1 & sof=0: bit discarded, no error.
  - bit_valid=0: no change.
- SHIFT, bit_valid=0: stall, hold everything. No timeout; gaps of any length are legal.
- SHIFT, bit_valid=1 & sof=0: accept bit, counter+1.
  - When the accepted bit is bit number BITWIDTH (counter was BITWIDTH-1), on that same edge:
    - word <= assembled value.
    - word_valid <= 1 for exactly one cycle.
    - counter <= 0, state <= IDLE.
- SHIFT, bit_valid=1 & sof=1 (early sof, any counter value including BITWIDTH-1):
  - frame_err <= 1 for one cycle.
  - Partial word discarded; word and word_valid untouched.
  - The sof bit becomes the first bit of a new word: counter=1, stay in SHIFT.
- sof=1 with bit_valid=0 is ignored in all states.
- Bit placement:
  - MSB_FIRST=1: shift left, insert at LSB; first bit ends in word[BITWIDTH-1].
  - MSB_FIRST=0: shift right, insert at MSB; first bit ends in word[0].
- Latency: word/word_valid appear the cycle after the clock edge that samples the last bit (one register stage).
- word holds its value between completions and changes only together with word_valid=1.
- busy=1 exactly while state==SHIFT. It is 0 in the word_valid cycle. It stays 1 through a frame_err restart.
- Back-to-back: a new sof+bit in the cycle immediately after the last bit is accepted (the FSM is in IDLE that cycle). Zero-bubble word streaming is supported.
- Reset mid-word: the partial word is lost, and word returns to 0 immediately (asynchronous).

Decomposition:
- Package sipo_deser_pkg holds:
  - State encoding localparams ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - A counter-width helper function.
- No sub-module. The shift register, counter and FSM are a single always block plus output registers.
- Bench-level top instantiates sipo_word_deser feeding reg_nbit (word -> a, word_valid -> enable), with a shared clk/rst_n.

Test Plan:
- Reset: rst_n=0 while bit_valid toggles -> word=16'h0000, word_valid=0, busy=0, frame_err=0. Release, then 3 idle cycles -> outputs unchanged.
- MSB_FIRST=1, BITWIDTH=16, send 16'hA5C3 MSB first (sof on first bit, no gaps) -> exactly one word_valid pulse one cycle after the 16th bit edge, word=16'hA5C3. Downstream reg_nbit q=16'hA5C3 one cycle later.
- Same 16'hA5C3 with bit_valid deasserted for 4 cycles after bits 5 and 11 -> word=16'hA5C3, one pulse, busy held high through the gaps.
- Early sof: send 9 bits, then sof + 16 bits of 16'h1234 -> one frame_err pulse on the restart cycle, no word_valid for the aborted frame, then word=16'h1234.
- Back-to-back 16'hFFFF then 16'h0001 with sof on the cycle right after the last bit -> two word_valid pulses 16 cycles apart, word=16'hFFFF then 16'h0001. Bits without sof in IDLE beforehand are ignored.
- MSB_FIRST=0, BITWIDTH=8, send bits 1,0,0,0,0,0,0,0 -> word=8'h01. Then assert rst_n=0 after 4 bits of the next word -> word=8'h00, busy=0 immediately.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// sipo_deser_pkg: FSM encoding and counter sizing shared by the serial word deserializer.
package sipo_deser_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/reg_nbit.sv
// reg_nbit: N-bit register that loads a when enable is high, async active-low reset.
module reg_nbit #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic         enable,
  output logic [N-1:0] q
);
  logic [N-1:0] q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else        q_q <= enable ? a : q_q;
  assign q = q_q;
endmodule

// File: rtl/sipo_word_deser.sv
// sipo_word_deser: assembles sof-framed serial bits into BITWIDTH-bit words.
module sipo_word_deser
  import sipo_deser_pkg::*;
#(
  parameter int BITWIDTH  = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bit_valid,
  input  logic                bit_in,
  input  logic                sof,
  output logic [BITWIDTH-1:0] word,
  output logic                word_valid,
  output logic                busy,
  output logic                frame_err
);
  localparam int CW = cnt_w(BITWIDTH);
  localparam logic [CW-1:0] LAST = CW'(BITWIDTH - 1);
  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BITWIDTH-1:0] sr_q, sr_d, word_q, word_d, ins;
  logic                wv_q, wv_d, err_q, err_d, take;
  // Stale bits left by an aborted frame are pushed out by the next full word.
  assign ins  = MSB_FIRST ? {sr_q[BITWIDTH-2:0], bit_in} : {bit_in, sr_q[BITWIDTH-1:1]};
  assign take = bit_valid && (sof || state_q == ST_SHIFT);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    word_d  = word_q;
    wv_d    = 1'b0;
    err_d   = 1'b0;
    if (take) begin
      sr_d  = ins;
      err_d = sof && state_q == ST_SHIFT;
      if (sof) begin
        cnt_d   = CW'(1);
        state_d = ST_SHIFT;
      end else if (cnt_q == LAST) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        word_d  = ins;
        wv_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      word_q  <= '0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      wv_q    <= wv_d;
      err_q   <= err_d;
    end
  assign word       = word_q;
  assign word_valid = wv_q;
  assign busy       = state_q == ST_SHIFT;
  assign frame_err  = err_q;
endmodule
